// File: rtl/sram_like_mem_responder.sv
// SRAM-like responder below the data cache: one request at a time, programmable
// address/data latency, backed by a word-organised memory array.
`timescale 1ns/1ps
module sram_like_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned ADDR_LAT   = 0,
    parameter int unsigned DATA_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    localparam int unsigned MAX_LAT = (ADDR_LAT > DATA_LAT) ? ADDR_LAT : DATA_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_LAT);
    // The handshake cycle is the first data-phase cycle, so BUSY lasts DATA_LAT-1
    // cycles and DATA_LAT=1 commits straight from IDLE; data_ok lands at handshake+DATA_LAT.
    localparam logic [CNT_W-1:0] BUSY_LAST = (DATA_LAT > 1) ? CNT_W'(DATA_LAT - 2) : '0;
    localparam bit DIRECT_RESP = (DATA_LAT <= 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             lat_wr, lat_wr_n;
    logic [1:0]       lat_size, lat_size_n;
    logic [31:0]      lat_addr, lat_addr_n;
    logic [31:0]      lat_wdata, lat_wdata_n;

    logic             fire;
    logic             acc_wr;
    logic [1:0]       acc_size;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       lane_mask;
    logic [31:0]      bit_mask;
    logic [ADDR_WIDTH-1:0] idx;
    logic             unused_addr_bits;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    byte_mask = 4'b0001 << off;
            2'd1:    byte_mask = off[1] ? 4'b1100 : 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        lat_wr_n     = lat_wr;
        lat_size_n   = lat_size;
        lat_addr_n   = lat_addr;
        lat_wdata_n  = lat_wdata;
        fire         = 1'b0;
        data_addr_ok = 1'b0;
        acc_wr       = lat_wr;
        acc_size     = lat_size;
        acc_addr     = lat_addr;
        acc_wdata    = lat_wdata;
        case (state)
            IDLE: begin
                data_addr_ok = data_req && (cnt == ADDR_LAST);
                acc_wr       = data_wr;
                acc_size     = data_size;
                acc_addr     = data_addr;
                acc_wdata    = data_wdata;
                if (data_addr_ok) begin
                    lat_wr_n    = data_wr;
                    lat_size_n  = data_size;
                    lat_addr_n  = data_addr;
                    lat_wdata_n = data_wdata;
                    cnt_n       = '0;
                    if (DIRECT_RESP) begin
                        fire    = 1'b1;
                        state_n = RESP;
                    end else begin
                        state_n = BUSY;
                    end
                end else if (data_req) begin
                    if (cnt != ADDR_LAST) cnt_n = cnt + CNT_W'(1);
                end else begin
                    cnt_n = '0;
                end
            end
            BUSY: begin
                if (cnt == BUSY_LAST) begin
                    fire    = 1'b1;
                    cnt_n   = '0;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign lane_mask = byte_mask(acc_size, acc_addr[1:0]);
    assign bit_mask  = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    assign idx       = acc_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^acc_addr[31:ADDR_WIDTH+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_wr       <= 1'b0;
            lat_size     <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            data_data_ok <= 1'b0;
            data_rdata   <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            lat_wr       <= lat_wr_n;
            lat_size     <= lat_size_n;
            lat_addr     <= lat_addr_n;
            lat_wdata    <= lat_wdata_n;
            data_data_ok <= fire;
            if (fire && !acc_wr) data_rdata <= mem[idx];
        end
    end

    // Array is not reset; writes are blocked while reset is held so a dropped request never commits.
    always_ff @(posedge clk) begin
        if (fire && acc_wr && !rst)
            mem[idx] <= (mem[idx] & ~bit_mask) | (acc_wdata & bit_mask);
    end

endmodule

// File: tb/tb_sram_like_mem_responder.sv
// Bench for sram_like_mem_responder: a zero/one-latency instance and a 2/3-latency
// instance, expected read data queued at issue and compared at response.
`timescale 1ns/1ps
module tb_sram_like_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        f_req, f_wr, f_addr_ok, f_data_ok;
    logic [1:0]  f_size;
    logic [31:0] f_addr, f_wdata, f_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;

    sram_like_mem_responder #(.ADDR_WIDTH(10), .ADDR_LAT(0), .DATA_LAT(1)) u_fast (
        .clk(clk), .rst(rst), .data_req(f_req), .data_wr(f_wr), .data_size(f_size),
        .data_addr(f_addr), .data_wdata(f_wdata), .data_rdata(f_rdata),
        .data_addr_ok(f_addr_ok), .data_data_ok(f_data_ok)
    );

    sram_like_mem_responder #(.ADDR_WIDTH(10), .ADDR_LAT(2), .DATA_LAT(3)) u_slow (
        .clk(clk), .rst(rst), .data_req(s_req), .data_wr(s_wr), .data_size(s_size),
        .data_addr(s_addr), .data_wdata(s_wdata), .data_rdata(s_rdata),
        .data_addr_ok(s_addr_ok), .data_data_ok(s_data_ok)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic drive(input bit slow, input logic req, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (slow) begin
            s_req = req; s_wr = wr; s_size = size; s_addr = addr; s_wdata = wdata;
        end else begin
            f_req = req; f_wr = wr; f_size = size; f_addr = addr; f_wdata = wdata;
        end
    endtask

    function automatic logic addr_ok_of(input bit slow);
        return slow ? s_addr_ok : f_addr_ok;
    endfunction

    function automatic logic data_ok_of(input bit slow);
        return slow ? s_data_ok : f_data_ok;
    endfunction

    function automatic logic [31:0] rdata_of(input bit slow);
        return slow ? s_rdata : f_rdata;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            bit en;
            case (size)
                2'd0:    en = (i == int'(off));
                2'd1:    en = off[1] ? (i >= 2) : (i < 2);
                default: en = 1'b1;
            endcase
            if (en) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

    // Starts aligned at posedge+1 in cycle 0; returns aligned at posedge+1 in the cycle after data_ok.
    task automatic bus_op(input bit slow, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                          output int a_cyc, output int d_cyc, output int extra_ok,
                          output logic [31:0] rd);
        int cyc;
        cyc = 0; a_cyc = -1; d_cyc = -1; extra_ok = 0; rd = 'x;
        drive(slow, 1'b1, wr, size, addr, wdata);
        while (cyc < 20) begin
            #2;
            if (addr_ok_of(slow)) begin a_cyc = cyc; break; end
            @(posedge clk); #1; cyc++;
        end
        if (a_cyc >= 0) begin
            @(posedge clk); #1; cyc++;
            if (!hold) drive(slow, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
            while (cyc < 40) begin
                #2;
                if (data_ok_of(slow)) begin d_cyc = cyc; rd = rdata_of(slow); break; end
                if (addr_ok_of(slow)) extra_ok++;
                @(posedge clk); #1; cyc++;
            end
        end
        drive(slow, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (f_data_ok !== 1'b0) begin failures++; $display("FAIL reset_f_data_ok got=%b exp=0", f_data_ok); end
        checks++; if (f_rdata !== 32'h0) begin failures++; $display("FAIL reset_f_rdata got=%h exp=00000000", f_rdata); end
        checks++; if (s_data_ok !== 1'b0) begin failures++; $display("FAIL reset_s_data_ok got=%b exp=0", s_data_ok); end
        checks++; if (s_rdata !== 32'h0) begin failures++; $display("FAIL reset_s_rdata got=%h exp=00000000", s_rdata); end
        checks++; if (f_addr_ok !== 1'b0) begin failures++; $display("FAIL reset_f_addr_ok got=%b exp=0", f_addr_ok); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word;
        int a, d, x; logic [31:0] rd, e;
        bus_op(1'b0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, a, d, x, rd);
        checks++; if (a !== 0) begin failures++; $display("FAIL word_wr_addr_ok_cycle got=%0d exp=0", a); end
        checks++; if (d !== 1) begin failures++; $display("FAIL word_wr_data_ok_cycle got=%0d exp=1", d); end
        checks++; if (f_data_ok !== 1'b0) begin failures++; $display("FAIL word_data_ok_pulse got=%b exp=0", f_data_ok); end
        exp_q.push_back(32'hDEADBEEF);
        bus_op(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, a, d, x, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL word_rd got=%h exp=%h", rd, e); end
        checks++; if (a !== 0) begin failures++; $display("FAIL word_b2b_addr_ok_cycle got=%0d exp=0", a); end
        checks++; if (d !== 1) begin failures++; $display("FAIL word_rd_data_ok_cycle got=%0d exp=1", d); end
    endtask

    task automatic test_byte;
        int a, d, x; logic [31:0] rd, e;
        bus_op(1'b0, 1'b1, 2'd2, 32'h10, 32'h11223344, 1'b0, a, d, x, rd);
        bus_op(1'b0, 1'b1, 2'd0, 32'h13, 32'hAA000000, 1'b0, a, d, x, rd);
        checks++; if (f_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rdata_held_on_write got=%h exp=deadbeef", f_rdata); end
        exp_q.push_back(32'hAA223344);
        bus_op(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, a, d, x, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL byte_write got=%h exp=%h", rd, e); end
    endtask

    task automatic test_half;
        int a, d, x; logic [31:0] rd, e;
        bus_op(1'b0, 1'b1, 2'd2, 32'h10, 32'h11223344, 1'b0, a, d, x, rd);
        bus_op(1'b0, 1'b1, 2'd1, 32'h10, 32'h0000BEEF, 1'b0, a, d, x, rd);
        exp_q.push_back(32'h1122BEEF);
        bus_op(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, a, d, x, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL half_low got=%h exp=%h", rd, e); end
        bus_op(1'b0, 1'b1, 2'd1, 32'h13, 32'hCAFE0000, 1'b0, a, d, x, rd);
        exp_q.push_back(32'hCAFEBEEF);
        bus_op(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, a, d, x, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL half_misaligned_hi got=%h exp=%h", rd, e); end
        bus_op(1'b0, 1'b1, 2'd1, 32'h11, 32'h00001234, 1'b0, a, d, x, rd);
        exp_q.push_back(32'hCAFE1234);
        bus_op(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, a, d, x, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL half_misaligned_lo got=%h exp=%h", rd, e); end
    endtask

    task automatic test_alias;
        int a, d, x; logic [31:0] rd, e;
        bus_op(1'b0, 1'b1, 2'd2, 32'h10000004, 32'h12345678, 1'b0, a, d, x, rd);
        exp_q.push_back(32'h12345678);
        bus_op(1'b0, 1'b0, 2'd2, 32'h00000004, 32'h0, 1'b0, a, d, x, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL alias got=%h exp=%h", rd, e); end
    endtask

    task automatic test_latency;
        int a, d, x; logic [31:0] rd, e;
        bus_op(1'b1, 1'b1, 2'd2, 32'h40, 32'hA5A50F0F, 1'b1, a, d, x, rd);
        checks++; if (a !== 2) begin failures++; $display("FAIL lat_addr_ok_cycle got=%0d exp=2", a); end
        checks++; if (d !== 5) begin failures++; $display("FAIL lat_data_ok_cycle got=%0d exp=5", d); end
        checks++; if (x !== 0) begin failures++; $display("FAIL lat_extra_addr_ok got=%0d exp=0", x); end
        checks++; if (s_data_ok !== 1'b0) begin failures++; $display("FAIL lat_data_ok_pulse got=%b exp=0", s_data_ok); end
        exp_q.push_back(32'hA5A50F0F);
        bus_op(1'b1, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, a, d, x, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL lat_rd got=%h exp=%h", rd, e); end
        checks++; if (d !== 5) begin failures++; $display("FAIL lat_rd_data_ok_cycle got=%0d exp=5", d); end
    endtask

    task automatic test_abort;
        int a, d, x, seen; logic [31:0] rd;
        seen = 0;
        drive(1'b1, 1'b1, 1'b1, 2'd2, 32'h44, 32'hFFFFFFFF);
        repeat (2) begin
            #1; if (s_addr_ok) seen++;
            @(posedge clk); #1;
        end
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (2) begin
            #1; if (s_addr_ok || s_data_ok) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_handshake got=%0d exp=0", seen); end
        bus_op(1'b1, 1'b1, 2'd2, 32'h44, 32'h01020304, 1'b0, a, d, x, rd);
        checks++; if (a !== 2) begin failures++; $display("FAIL abort_cnt_cleared got=%0d exp=2", a); end
    endtask

    task automatic test_reset_busy;
        int a, d, x, pulses; logic [31:0] rd, e;
        bus_op(1'b1, 1'b1, 2'd2, 32'h80, 32'h00000000, 1'b0, a, d, x, rd);
        drive(1'b1, 1'b1, 1'b1, 2'd2, 32'h80, 32'h55555555);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s_addr_ok !== 1'b1) begin failures++; $display("FAIL rstbusy_handshake got=%b exp=1", s_addr_ok); end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (s_data_ok) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rstbusy_no_data_ok got=%0d exp=0", pulses); end
        exp_q.push_back(32'h00000000);
        bus_op(1'b1, 1'b0, 2'd2, 32'h80, 32'h0, 1'b0, a, d, x, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL rstbusy_no_commit got=%h exp=%h", rd, e); end
    endtask

    task automatic test_back_to_back;
        int a, d, x; logic [31:0] rd, e;
        logic [31:0] mdl [4];
        for (int w = 0; w < 4; w++) begin
            mdl[w] = $urandom;
            bus_op(1'b0, 1'b1, 2'd2, 32'h200 + 32'(w * 4), mdl[w], 1'b0, a, d, x, rd);
        end
        for (int n = 0; n < 16; n++) begin
            int w;
            logic [1:0] off, size;
            logic wr;
            logic [31:0] wdata;
            w = int'($urandom_range(0, 3));
            off = 2'($urandom_range(0, 3));
            size = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            wdata = $urandom;
            if (wr) begin
                mdl[w] = merge(mdl[w], wdata, size, off);
                bus_op(1'b0, 1'b1, size, 32'h200 + 32'(w * 4) + 32'(off), wdata, 1'b0, a, d, x, rd);
            end else begin
                exp_q.push_back(mdl[w]);
                bus_op(1'b0, 1'b0, size, 32'h200 + 32'(w * 4) + 32'(off), 32'h0, 1'b0, a, d, x, rd);
                e = exp_q.pop_front();
                checks++; if (rd !== e) begin failures++; $display("FAIL b2b_rd[%0d] got=%h exp=%h", n, rd, e); end
            end
            checks++; if (a !== 0 || d !== 1) begin failures++; $display("FAIL b2b_timing[%0d] got=%0d/%0d exp=0/1", n, a, d); end
        end
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_alias;
        test_latency;
        test_abort;
        test_reset_busy;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
